// File: rtl/ahb_lite_master.sv
// ahb_lite_master: pipelined single-beat AHB-Lite initiator with in-order responses.
// Optional wait-state timeout enabled by defining AHBM_TIMEOUT_EN.
module ahb_lite_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [1:0]        hsize,
  output logic              hwrite,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);
  typedef enum logic [2:0] {IDLE, ADDR, PIPE, DATA, ERR} state_t;
  state_t state, state_n;
  logic a_valid, a_write;
  logic [ADDR_W-1:0] a_addr;
  logic [1:0] a_size;
  logic [DATA_W-1:0] a_wdata;
  logic d_valid, d_write;
  logic [DATA_W-1:0] d_wdata;
  logic ready_int, accept, move, done_ok, err_edge, tout, a_next, d_next;
`ifdef AHBM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  assign tout = d_valid && !hready && wait_cnt == 8'd254;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) wait_cnt <= '0;
    else wait_cnt <= (hready || err_edge) ? '0 : (d_valid && wait_cnt != 8'hff) ? wait_cnt + 8'd1 : wait_cnt;
`else
  assign tout = 1'b0;
`endif
  // Error or timeout cancels the pending address phase; ERR idles one cycle before reissue.
  always_comb begin
    err_edge = d_valid && (hresp || tout);
    done_ok = d_valid && hready && !hresp && !tout;
    ready_int = state != ERR && (!a_valid || (hready && !hresp));
    accept = cmd_valid && ready_int;
    move = a_valid && hready && !err_edge && state != ERR;
    a_next = accept || (a_valid && !move);
    d_next = move || (d_valid && !done_ok && !err_edge);
    state_n = err_edge ? ERR : a_next ? (d_next ? PIPE : ADDR) : (d_next ? DATA : IDLE);
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_addr <= '0;
      a_size <= '0;
      a_wdata <= '0;
      d_valid <= 1'b0;
      d_write <= 1'b0;
      d_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      a_valid <= a_next;
      d_valid <= d_next;
      if (accept) begin
        a_write <= cmd_write;
        a_addr <= cmd_addr;
        a_size <= cmd_size == 2'd3 ? 2'd2 : cmd_size;
        a_wdata <= cmd_write ? cmd_wdata : '0;
      end
      if (move) begin
        d_write <= a_write;
        d_wdata <= a_wdata;
      end
      rsp_valid <= done_ok || err_edge;
      rsp_error <= err_edge;
      rsp_rdata <= (done_ok && !d_write) ? hrdata : '0;
    end
  assign cmd_ready = n_rst && ready_int;
  assign htrans = (state == ADDR || state == PIPE) ? 2'b10 : 2'b00;
  assign hsel = htrans[1] || d_valid;
  assign haddr = a_addr;
  assign hsize = a_size;
  assign hwrite = a_write;
  assign hburst = 3'b000;
  assign hwdata = d_valid ? d_wdata : '0;
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: scoreboard bench driving ahb_lite_master against a scripted slave.
module tb_ahb_lite_master;
  logic clk = 0, n_rst = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [3:0] cmd_addr = 0;
  logic [1:0] cmd_size = 0;
  logic [31:0] cmd_wdata = 0;
  logic rsp_valid, rsp_error, hsel, hwrite;
  logic [31:0] rsp_rdata, hwdata;
  logic [3:0] haddr;
  logic [1:0] htrans, hsize;
  logic [2:0] hburst;
  logic [31:0] hrdata = 0;
  logic hready = 1, hresp = 0;
  typedef struct packed {logic err; logic [31:0] rdata;} rsp_t;
  rsp_t sb[$];
  rsp_t m_exp;
  int checks = 0, errors = 0, rsp_cnt = 0, base;
  ahb_lite_master #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .n_rst(n_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize), .hwrite(hwrite),
    .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (rsp_valid) begin
      rsp_cnt++;
      if (sb.size() == 0) check("rsp_extra", 1, 0);
      else begin
        m_exp = sb.pop_front();
        check("rsp_rdata", rsp_rdata, m_exp.rdata);
        check("rsp_error", rsp_error, m_exp.err);
      end
    end
  task automatic issue(input logic w, input logic [3:0] a, input logic [1:0] s, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = wd;
    #1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("cmd_accept", cmd_ready, 1);
    sb.push_back('{err: e_err, rdata: e_rd});
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    check("drain", sb.size(), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    cmd_valid = 1;
    #2;
    check("reset_outs", {hsel, haddr, htrans, hsize, hwrite, hburst, hwdata, rsp_valid, rsp_rdata, rsp_error, cmd_ready}, 0);
    cmd_valid = 0;
    repeat (2) @(negedge clk);
    n_rst = 1;
    // word write
    issue(1, 4'd0, 2'd2, 32'hA1B2C3D4, 0, 0);
    check("ww_addr", {htrans, haddr, hsize, hwrite, hsel, hburst}, {2'b10, 4'd0, 2'd2, 1'b1, 1'b1, 3'd0});
    @(posedge clk); #1;
    check("ww_data", {htrans, hsel, hwdata}, {2'b00, 1'b1, 32'hA1B2C3D4});
    drain(20);
    // back-to-back write then read
    hrdata = 32'h0000_0040;
    issue(1, 4'd12, 2'd0, 32'h03, 0, 0);
    check("b2b_a1", {htrans, haddr, hsize, hwrite}, {2'b10, 4'd12, 2'd0, 1'b1});
    issue(0, 4'd8, 2'd2, 32'h0, 0, 32'h40);
    check("b2b_a2", {htrans, haddr, hwrite, hwdata}, {2'b10, 4'd8, 1'b0, 32'h03});
    drain(20);
    // address-phase wait states
    hrdata = 32'h55AA;
    base = rsp_cnt;
    issue(0, 4'd5, 2'd2, 0, 0, 32'h55AA);
    hready = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("ws_addr_hold", {htrans, haddr, hsel}, {2'b10, 4'd5, 1'b1});
    end
    check("ws_no_rsp", rsp_cnt - base, 0);
    hready = 1;
    drain(20);
    check("ws_once", rsp_cnt - base, 1);
    // data-phase wait states on a write
    base = rsp_cnt;
    issue(1, 4'd1, 2'd2, 32'hDEADBEEF, 0, 0);
    @(posedge clk); #1;
    hready = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("ws_data_hold", {htrans, hsel, hwdata, rsp_valid}, {2'b00, 1'b1, 32'hDEADBEEF, 1'b0});
    end
    hready = 1;
    drain(20);
    check("ws_data_once", rsp_cnt - base, 1);
    // error response cancels the pending read, which is reissued
    hrdata = 32'h77;
    issue(1, 4'd4, 2'd2, 32'h1234, 1, 0);
    issue(0, 4'd13, 2'd2, 0, 0, 32'h77);
    hresp = 1; hready = 0;
    #1;
    check("err_pipe", {htrans, haddr, cmd_ready}, {2'b10, 4'd13, 1'b0});
    @(posedge clk); #1;
    check("err_idle", {htrans, hsel, cmd_ready}, {2'b00, 1'b0, 1'b0});
    hready = 1;
    @(posedge clk); #1;
    hresp = 0;
    check("err_reissue", {htrans, haddr, hwrite, hsel}, {2'b10, 4'd13, 1'b0, 1'b1});
    drain(20);
    // reset in the middle of a pipelined pair
    issue(1, 4'd2, 2'd2, 32'hCAFE, 0, 0);
    issue(0, 4'd3, 2'd2, 0, 0, 0);
    check("rst_pipe", {htrans, haddr, hsel}, {2'b10, 4'd3, 1'b1});
    n_rst = 0;
    sb.delete();
    #1;
    check("rst_async", {hsel, haddr, htrans, hsize, hwrite, hburst, hwdata, rsp_valid, rsp_rdata, rsp_error, cmd_ready}, 0);
    base = rsp_cnt;
    repeat (2) @(negedge clk);
    n_rst = 1;
    repeat (3) @(negedge clk);
    check("rst_dropped", rsp_cnt - base, 0);
    // first command after reset, size 3 folded to word
    hrdata = 32'h9999_0001;
    issue(0, 4'd7, 2'd3, 0, 0, 32'h9999_0001);
    check("post_rst_addr", {htrans, haddr, hsize, hwrite, hsel, hburst}, {2'b10, 4'd7, 2'd2, 1'b0, 1'b1, 3'd0});
    drain(20);
`ifdef AHBM_TIMEOUT_EN
    begin
      int n = 0;
      issue(0, 4'd0, 2'd2, 0, 1, 0);
      @(posedge clk); #1;
      hready = 0;
      while (!rsp_valid && n < 400) begin
        @(negedge clk); n++;
      end
      check("tout_rsp", rsp_valid, 1);
      @(posedge clk); #1;
      check("tout_idle", {htrans, hsel}, 0);
      hready = 1;
      drain(20);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
